// File: rtl/shared_pkg.sv
// Shared types and widths for the SPI master and its slave-side counterparts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shared_pkg;

  localparam int MEM_WIDTH   = 8;
  localparam int FRAME_WIDTH = MEM_WIDTH + 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SHIFT  = 3'd2,
    TURN   = 3'd3,
    RECV   = 3'd4,
    END    = 3'd5
  } master_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: PISO frame register, SIPO receive register, bit counter.
// Latency: load/shift/sample take effect on the next clock edge; o_rx_next is combinational.
// Backpressure: none, purely slaved to the enables from the controlling FSM.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_load, i_frame          parallel load of the outgoing frame
//   i_shift                  shift frame register left by one (MSB leaves first)
//   i_cnt_load, i_cnt_val    load the bit counter
//   i_cnt_dec                decrement the bit counter
//   i_sample, i_miso         shift MISO into the receive register LSB
//   o_tx_msb                 current outgoing bit
//   o_cnt                    bit counter value
//   o_rx_next                receive register value after the current sample
module spi_master_shifter
  import shared_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [FRAME_WIDTH-1:0] i_frame,
  input  logic                   i_shift,
  input  logic                   i_cnt_load,
  input  logic [3:0]             i_cnt_val,
  input  logic                   i_cnt_dec,
  input  logic                   i_sample,
  input  logic                   i_miso,
  output logic                   o_tx_msb,
  output logic [3:0]             o_cnt,
  output logic [MEM_WIDTH-1:0]   o_rx_next
);

  logic [FRAME_WIDTH-1:0] r_tx_shift;
  logic [MEM_WIDTH-1:0]   r_rx_shift;
  logic [3:0]             r_cnt;
  logic [MEM_WIDTH-1:0]   w_rx_next;

  assign w_rx_next = {r_rx_shift[MEM_WIDTH-2:0], i_miso};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_cnt      <= '0;
    end else begin
      if (i_load) begin
        r_tx_shift <= i_frame;
      end else if (i_shift) begin
        r_tx_shift <= {r_tx_shift[FRAME_WIDTH-2:0], 1'b0};
      end
      if (i_cnt_load) begin
        r_cnt <= i_cnt_val;
      end else if (i_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (i_sample) begin
        r_rx_shift <= w_rx_next;
      end
    end
  end

  assign o_tx_msb  = r_tx_shift[FRAME_WIDTH-1];
  assign o_cnt     = r_cnt;
  assign o_rx_next = w_rx_next;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {op,payload} MSB first on MOSI under SS_n, receives 8 bits back for RD_DATA.
// Latency: SS_n low 11 cycles per frame (19+TURNAROUND for RD_DATA); rsp_valid pulses in END.
// Backpressure: cmd_ready high only in IDLE; commands offered while busy are not latched.
//
// Ports:
//   i_clk, i_rst_n                        clock (also SPI bit clock), async active-low reset
//   i_cmd_valid, o_cmd_ready              host command handshake
//   i_cmd_op, i_cmd_data                  opcode and payload
//   o_rsp_valid, o_rsp_data               read-data response (one-cycle pulse, data held)
//   o_busy                                high in every state but IDLE
//   o_ss_n, o_mosi, i_miso                SPI pins
// TURNAROUND (1..7): idle cycles between last MOSI bit and first MISO sample.
module spi_master_ctrl
  import shared_pkg::*;
#(
  parameter int TURNAROUND = 1
)
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [MEM_WIDTH-1:0] i_cmd_data,
  output logic                 o_rsp_valid,
  output logic [MEM_WIDTH-1:0] o_rsp_data,
  output logic                 o_busy,
  output logic                 o_ss_n,
  output logic                 o_mosi,
  input  logic                 i_miso
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_WIDTH - 1);
  localparam logic [3:0] TURN_LOAD  = 4'(TURNAROUND - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(MEM_WIDTH - 1);

  master_state_e        r_state;
  logic                 r_is_read;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_data;

  logic                 w_hs;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_cnt_load;
  logic [3:0]           w_cnt_val;
  logic                 w_cnt_dec;
  logic                 w_sample;
  logic                 w_tx_msb;
  logic [3:0]           w_cnt;
  logic                 w_cnt_zero;
  logic [MEM_WIDTH-1:0] w_rx_next;

  assign w_hs       = i_cmd_valid && r_cmd_ready;
  assign w_cnt_zero = (w_cnt == 4'd0);

  // Datapath enables decoded from the current state; the counter is shared by
  // SHIFT, TURN and RECV and reloaded on each phase change.
  always_comb begin
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_val  = 4'd0;
    w_cnt_dec  = 1'b0;
    w_sample   = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_hs;
      end
      SELECT: begin
        w_shift    = 1'b1;
        w_cnt_load = 1'b1;
        w_cnt_val  = SHIFT_LOAD;
      end
      SHIFT: begin
        w_shift   = !w_cnt_zero;
        w_cnt_dec = !w_cnt_zero;
        if (w_cnt_zero && r_is_read) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = TURN_LOAD;
        end
      end
      TURN: begin
        w_cnt_dec = !w_cnt_zero;
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = RECV_LOAD;
        end
      end
      RECV: begin
        w_sample  = 1'b1;
        w_cnt_dec = !w_cnt_zero;
      end
      default: ;
    endcase
  end

  spi_master_shifter u_shifter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_frame    ({i_cmd_op, i_cmd_data}),
    .i_shift    (w_shift),
    .i_cnt_load (w_cnt_load),
    .i_cnt_val  (w_cnt_val),
    .i_cnt_dec  (w_cnt_dec),
    .i_sample   (w_sample),
    .i_miso     (i_miso),
    .o_tx_msb   (w_tx_msb),
    .o_cnt      (w_cnt),
    .o_rx_next  (w_rx_next)
  );

  // Outputs are set on the edge that enters each state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_is_read   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_state     <= SELECT;
            r_is_read   <= (spi_op_e'(i_cmd_op) == RD_DATA);
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_ss_n      <= 1'b0;
            r_mosi      <= i_cmd_op[1];
          end
        end
        SELECT: begin
          r_state <= SHIFT;
          r_mosi  <= w_tx_msb;
        end
        SHIFT: begin
          if (w_cnt_zero) begin
            r_mosi <= 1'b0;
            if (r_is_read) begin
              r_state <= TURN;
            end else begin
              r_state <= END;
              r_ss_n  <= 1'b1;
            end
          end else begin
            r_mosi <= w_tx_msb;
          end
        end
        TURN: begin
          if (w_cnt_zero) begin
            r_state <= RECV;
          end
        end
        RECV: begin
          if (w_cnt_zero) begin
            // w_rx_next already includes the sample taken on this edge.
            r_state     <= END;
            r_ss_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rx_next;
          end
        end
        END: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_ss_n      <= 1'b1;
          r_mosi      <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_ss_n      = r_ss_n;
  assign o_mosi      = r_mosi;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (TURNAROUND 1 and 3) against a behavioural slave + RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_ctrl;
  import shared_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid_a, cmd_valid_b;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       miso;

  logic       ready_a, rv_a, busy_a, ss_a, mosi_a;
  logic [7:0] rd_a;
  logic       ready_b, rv_b, busy_b, ss_b, mosi_b;
  logic [7:0] rd_b;

  spi_master_ctrl #(.TURNAROUND(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid_a), .o_cmd_ready(ready_a),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data), .o_rsp_valid(rv_a), .o_rsp_data(rd_a),
    .o_busy(busy_a), .o_ss_n(ss_a), .o_mosi(mosi_a), .i_miso(miso)
  );

  spi_master_ctrl #(.TURNAROUND(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid_b), .o_cmd_ready(ready_b),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data), .o_rsp_valid(rv_b), .o_rsp_data(rd_b),
    .o_busy(busy_b), .o_ss_n(ss_b), .o_mosi(mosi_b), .i_miso(miso)
  );

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  // Slave model (driven by what actually appears on MOSI) and reference model (driven by intent).
  logic [7:0] slave_mem [256];
  logic [7:0] slave_wr, slave_rd;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr, ref_rd;
  logic [7:0] last_rsp;

  // Per-frame observations.
  logic [10:0] res_vec;
  int          res_len, res_rv_cnt, res_rv_pos, res_gap, res_bad;
  logic [7:0]  res_rsp;
  bit          res_timeout;

  function automatic logic o_ready(); return sel ? ready_b : ready_a; endfunction
  function automatic logic o_ss();    return sel ? ss_b    : ss_a;    endfunction
  function automatic logic o_mosi();  return sel ? mosi_b  : mosi_a;  endfunction
  function automatic logic o_busy();  return sel ? busy_b  : busy_a;  endfunction
  function automatic logic o_rv();    return sel ? rv_b    : rv_a;    endfunction
  function automatic logic [7:0] o_rd(); return sel ? rd_b : rd_a;    endfunction

  task automatic set_valid(input logic v);
    if (sel == 0) cmd_valid_a = v; else cmd_valid_b = v;
  endtask

  task automatic ref_apply(input logic [1:0] op, input logic [7:0] d, output logic [7:0] rsp);
    rsp = 8'h00;
    case (op)
      2'b00: ref_wr = d;
      2'b01: ref_mem[ref_wr] = d;
      2'b10: ref_rd = d;
      default: rsp = ref_mem[ref_rd];
    endcase
  endtask

  // Issue one command and watch the whole frame, acting as the SPI slave. Called and
  // returns on a negedge; returns in the END cycle (first SS_n-high cycle after the frame).
  task automatic run_cmd(input int s, input logic [1:0] op, input logic [7:0] data,
                         input bit hold, input logic [1:0] nop, input logic [7:0] ndata,
                         input bit ovr_en, input logic [7:0] ovr);
    int hs_wait;
    int c;
    int tturn;
    logic [7:0] rd_val;
    sel = s;
    cmd_op = op;
    cmd_data = data;
    set_valid(1'b1);
    hs_wait = 0;
    res_timeout = 0;
    res_len = 0; res_rv_cnt = 0; res_rv_pos = -1; res_bad = 0; res_vec = '0; res_rsp = '0;
    while (!o_ready()) begin
      hs_wait++;
      if (hs_wait > 50) begin
        res_timeout = 1;
        break;
      end
      @(negedge clk);
    end
    res_gap = hs_wait + 1;
    if (res_timeout) begin
      set_valid(1'b0);
      return;
    end
    @(negedge clk);
    if (hold) begin
      cmd_op = nop;
      cmd_data = ndata;
    end else begin
      set_valid(1'b0);
    end
    tturn = s ? 3 : 1;
    rd_val = ovr_en ? ovr : slave_mem[slave_rd];
    c = 0;
    while (1) begin
      if (o_ss() == 1'b0) begin
        if (res_len < 11) res_vec = {res_vec[9:0], o_mosi()};
        else if (o_mosi()) res_bad++;
        res_len++;
      end else if (o_mosi()) begin
        res_bad++;
      end
      if (o_rv()) begin
        res_rv_cnt++;
        res_rv_pos = c;
        res_rsp = o_rd();
      end
      if (o_ready() || !o_busy()) res_bad++;
      if (c >= 11 + tturn && c < 19 + tturn) miso = rd_val[7 - (c - 11 - tturn)];
      else miso = 1'($urandom_range(0, 1));
      if (o_ss() == 1'b1) break;
      c++;
      if (c > 60) begin
        res_timeout = 1;
        break;
      end
      @(negedge clk);
    end
    if (res_len >= 11) begin
      case (res_vec[9:8])
        2'b00: slave_wr = res_vec[7:0];
        2'b01: slave_mem[slave_wr] = res_vec[7:0];
        2'b10: slave_rd = res_vec[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid_a = 0; cmd_valid_b = 0; cmd_op = 0; cmd_data = 0; miso = 0;
    repeat (3) @(negedge clk);
    sel = 0;
    vectors++;
    if ({o_ready(), o_ss(), o_mosi(), o_busy(), o_rv(), o_rd()} !== {5'b11000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy/ss/mosi/busy/rv/rd=%b required 11000_00000000",
               {o_ready(), o_ss(), o_mosi(), o_busy(), o_rv(), o_rd()});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_ready(), o_ss(), o_busy(), o_rv()} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release_idle: got rdy/ss/busy/rv=%b required 1100",
               {o_ready(), o_ss(), o_busy(), o_rv()});
    end
  endtask

  task automatic test_write();
    logic [7:0] r;
    ref_apply(2'b00, 8'hA5, r);
    run_cmd(0, 2'b00, 8'hA5, 0, 0, 0, 0, 0);
    vectors++;
    if (res_timeout || res_vec !== 11'b0_00_1010_0101 || res_len !== 11 || res_rv_cnt !== 0) begin
      miscompares++;
      $display("FAIL wr_addr_frame: got bits=%b len=%0d rv=%0d to=%0b required bits=00010100101 len=11 rv=0",
               res_vec, res_len, res_rv_cnt, res_timeout);
    end
    ref_apply(2'b01, 8'h3C, r);
    run_cmd(0, 2'b01, 8'h3C, 0, 0, 0, 0, 0);
    vectors++;
    if (res_timeout || res_vec !== 11'b0_01_0011_1100 || res_len !== 11 || res_gap < 2) begin
      miscompares++;
      $display("FAIL wr_data_frame: got bits=%b len=%0d gap=%0d required bits=00100111100 len=11 gap>=2",
               res_vec, res_len, res_gap);
    end
    vectors++;
    if (slave_mem[8'hA5] !== ref_mem[8'hA5]) begin
      miscompares++;
      $display("FAIL wr_ram_content: got mem[A5]=%h required %h", slave_mem[8'hA5], ref_mem[8'hA5]);
    end
  endtask

  task automatic test_read();
    logic [7:0] r;
    ref_apply(2'b10, 8'hA5, r);
    run_cmd(0, 2'b10, 8'hA5, 0, 0, 0, 0, 0);
    vectors++;
    if (res_vec !== 11'b1_10_1010_0101 || res_len !== 11 || res_rv_cnt !== 0) begin
      miscompares++;
      $display("FAIL rd_addr_frame: got bits=%b len=%0d rv=%0d required bits=11010100101 len=11 rv=0",
               res_vec, res_len, res_rv_cnt);
    end
    ref_apply(2'b11, 8'h5A, r);
    run_cmd(0, 2'b11, 8'h5A, 0, 0, 0, 0, 0);
    last_rsp = r;
    vectors++;
    if (res_len !== 20 || res_rv_cnt !== 1 || res_rv_pos !== 20 || res_rsp !== 8'h3C || res_gap !== 2 || res_bad !== 0) begin
      miscompares++;
      $display("FAIL rd_data_frame: got len=%0d rv=%0d pos=%0d rsp=%h gap=%0d bad=%0d required 20 1 20 3c 2 0",
               res_len, res_rv_cnt, res_rv_pos, res_rsp, res_gap, res_bad);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (o_rd() !== 8'h3C || o_rv() !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_data_hold: got rsp_data=%h rv=%b required 3c 0", o_rd(), o_rv());
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] r;
    int lows;
    ref_apply(2'b00, 8'h11, r);
    run_cmd(0, 2'b00, 8'h11, 1, 2'b01, 8'h77, 0, 0);
    vectors++;
    if (res_vec !== 11'b0_00_0001_0001 || res_len !== 11 || res_bad !== 0) begin
      miscompares++;
      $display("FAIL bp_first_frame: got bits=%b len=%0d bad=%0d required 00000010001 11 0",
               res_vec, res_len, res_bad);
    end
    ref_apply(2'b01, 8'h77, r);
    run_cmd(0, 2'b01, 8'h77, 0, 0, 0, 0, 0);
    vectors++;
    if (res_vec !== 11'b0_01_0111_0111 || res_gap !== 2 || res_len !== 11) begin
      miscompares++;
      $display("FAIL bp_second_frame: got bits=%b gap=%0d len=%0d required 00101110111 2 11",
               res_vec, res_gap, res_len);
    end
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_ss() == 1'b0) lows++;
    end
    vectors++;
    if (lows !== 0) begin
      miscompares++;
      $display("FAIL bp_accept_once: got %0d extra SS_n-low cycles required 0", lows);
    end
  endtask

  task automatic test_turnaround();
    run_cmd(1, 2'b11, 8'($urandom), 0, 0, 0, 1, 8'b1000_0001);
    vectors++;
    if (res_len !== 22 || res_rv_cnt !== 1 || res_rv_pos !== 22 || res_rsp !== 8'h81 || res_bad !== 0) begin
      miscompares++;
      $display("FAIL turn3_read: got len=%0d rv=%0d pos=%0d rsp=%h bad=%0d required 22 1 22 81 0",
               res_len, res_rv_cnt, res_rv_pos, res_rsp, res_bad);
    end
    @(negedge clk);
    sel = 0;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d, r;
    int exp_len;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = (i % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      ref_apply(op, d, r);
      exp_len = (op == 2'b11) ? 20 : 11;
      run_cmd(0, op, d, 0, 0, 0, 0, 0);
      if (op == 2'b11) last_rsp = r;
      vectors++;
      if (res_timeout || res_vec !== {op[1], op, d} || res_len !== exp_len || res_bad !== 0) begin
        miscompares++;
        $display("FAIL rand_frame[%0d]: got bits=%b len=%0d bad=%0d required bits=%b len=%0d bad=0",
                 i, res_vec, res_len, res_bad, {op[1], op, d}, exp_len);
      end
      vectors++;
      if (res_rv_cnt !== ((op == 2'b11) ? 1 : 0) || o_rd() !== last_rsp) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: got rv_cnt=%0d rsp_data=%h required rv_cnt=%0d rsp_data=%h",
                 i, res_rv_cnt, o_rd(), (op == 2'b11) ? 1 : 0, last_rsp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    sel = 0;
    cmd_op = 2'b11;
    cmd_data = 8'hFF;
    cmd_valid_a = 1'b1;
    for (int k = 0; k < 10 && !o_ready(); k++) @(negedge clk);
    @(negedge clk);
    cmd_valid_a = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_ss(), o_mosi(), o_busy()} !== 3'b011) begin
      miscompares++;
      $display("FAIL rst_pre_shift: got ss/mosi/busy=%b required 011", {o_ss(), o_mosi(), o_busy()});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_ready(), o_ss(), o_mosi(), o_busy(), o_rv(), o_rd()} !== {5'b11000, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_midframe: got rdy/ss/mosi/busy/rv/rd=%b required 11000_00000000",
               {o_ready(), o_ss(), o_mosi(), o_busy(), o_rv(), o_rd()});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_rv() || !o_ss() || !o_ready()) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL rst_release: got %0d non-idle cycles required 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i] = slave_mem[i];
    end
    slave_wr = 0; slave_rd = 0; ref_wr = 0; ref_rd = 0; last_rsp = 0;
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_turnaround();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI initiator (master) that drives the existing SPI slave + single-port RAM from a parallel host command interface.
- Accepts one 2-bit opcode + 8-bit payload per transaction and serialises the 10-bit frame {op, payload} MSB first on MOSI, framed by SS_n.
- For read-data (op 2'b11) it also receives the 8-bit RAM word back on MISO and returns it to the host.
- Sits between the testbench/host sequencer and the SPI slave wrapper, sharing its single clock.

Parameters:
- MEM_WIDTH, 8, payload and read-data width (from shared_pkg).
- FRAME_WIDTH, MEM_WIDTH+2, bits shifted per command frame.
- TURNAROUND, 1, idle cycles between last MOSI bit and first MISO sample for read-data (covers slave RAM latency); legal range 1..7.

Ports:
- clk  in  1  system clock; also the SPI bit clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
- cmd_op  in  2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- cmd_data  in  MEM_WIDTH  payload; don't-care for RD_DATA, but still transmitted.
- rsp_valid  out  1  one-cycle pulse when rsp_data is valid (RD_DATA only).
- rsp_data  out  MEM_WIDTH  word received on MISO; held until the next RD_DATA completes.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state goes to IDLE.
  - SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0.
  - Bit counter and shift registers are cleared.
- All outputs are registered.
- IDLE:
  - SS_n=1, cmd_ready=1.
  - On handshake: latch frame={cmd_op,cmd_data} and go to SELECT.
- SELECT (1 cycle): SS_n=0, MOSI=cmd_op[1] (the slave's write/read select bit). Go to SHIFT.
- SHIFT (FRAME_WIDTH cycles):
  - SS_n=0. MOSI = frame[9], frame[8], ..., frame[0], one bit per cycle.
  - A 4-bit counter runs 9 down to 0.
  - At count 0: go to TURN if op==11, else to END.
- TURN (TURNAROUND cycles): SS_n=0, MOSI=0. Go to RECV.
- RECV (MEM_WIDTH cycles):
  - SS_n=0, MOSI=0.
  - Sample MISO on each posedge, MSB first, shifting left into rx_shift.
  - After the 8th sample, go to END.
- END (1 cycle):
  - SS_n=1, MOSI=0.
  - If op==11: rsp_data<=rx_shift and rsp_valid=1 for exactly this cycle.
  - Go to IDLE.
- Frame lengths (SS_n low):
  - Write/RD_ADDR: 11 cycles.
  - RD_DATA: 11+TURNAROUND+8 cycles (20 at default).
- Minimum SS_n high gap between frames: 2 cycles (END + IDLE handshake).
- cmd_valid while busy: ignored, not queued. The host must hold cmd_valid until the handshake.
- No ordering enforcement. RD_DATA without a prior RD_ADDR is still sent; the returned data is whatever the slave drives.
- MISO is sampled only in RECV; its value in all other states is ignored.
- rsp_data changes only in END of an RD_DATA frame.

Decomposition:
- shared_pkg:
  - spi_op_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA).
  - master_state_e enum (IDLE, SELECT, SHIFT, TURN, RECV, END).
  - MEM_WIDTH and FRAME_WIDTH.
- Macros in spi_defines.svh: timescale only.
- One natural sub-module, spi_master_shifter: PISO for MOSI plus SIPO for MISO, with load/shift enables and bit counter. The FSM stays in spi_master_ctrl.

Test Plan:
- Reset: assert rst_n=0 in the middle of a SHIFT state -> same cycle SS_n=1, MOSI=0, busy=0, cmd_ready=1; rst_n release -> IDLE, no rsp_valid.
- WR_ADDR op=00 data=8'hA5:
  - SELECT MOSI=0.
  - MOSI over the 10 SHIFT cycles = 0,0,1,0,1,0,0,1,0,1.
  - SS_n low exactly 11 cycles; no rsp_valid.
- WR_DATA op=01 data=8'h3C after the 8'hA5 address -> slave RAM mem[8'hA5]==8'h3C one cycle after slave rx_valid; SS_n high ≥2 cycles between frames.
- RD_ADDR 8'hA5, then RD_DATA:
  - MOSI first bit 1.
  - SS_n low 20 cycles.
  - rsp_valid single pulse with rsp_data=8'h3C in END.
- Back-pressure: cmd_valid held high with new op while busy -> cmd_ready=0, the command is not latched until IDLE, then accepted exactly once.
- MISO stimulus 8'b1000_0001 driven directly in RECV, TURNAROUND=3 -> rsp_data=8'h81, SS_n low 22 cycles.
